pc_unit: RTL

Parametrised program-counter unit for the RISC-V fetch stage. It holds the current fetch address, advances it by a fixed step on an accepted fetch, and loads a new address on branch/jump redirect, trap entry, or trap return. It also provides halt/resume control and detects misaligned redirect targets. It sits between the core control logic and the instruction-memory request port.

---
 rtl/pc_pkg.sv | 13 +
 rtl/pc_adder.sv | 12 +
 rtl/pc_unit.sv | 92 +++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and default vectors for the fetch-stage program counter.
package pc_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } pc_state_e;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;
  localparam int unsigned STEP_DEF         = 4;

endpackage

// File: rtl/pc_adder.sv
// Sequential-address adder: base + STEP, wrapping modulo 2^XLEN.
module pc_adder #(
  parameter int          XLEN = 32,
  parameter int unsigned STEP = 4
) (
  input  logic [XLEN-1:0] base,
  output logic [XLEN-1:0] sum
);

  assign sum = base + XLEN'(STEP);

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with redirect, trap entry/return and halt.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
  parameter int unsigned      STEP         = STEP_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_in,
  input  logic            fetch_ready_in,
  input  logic            redirect_in,
  input  logic [XLEN-1:0] redirect_target_in,
  input  logic            trap_in,
  input  logic            mret_in,
  input  logic            halt_in,
  input  logic            resume_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_next_seq_out,
  output logic            fetch_valid_out,
  output logic [XLEN-1:0] epc_out,
  output logic            misalign_out
);

  pc_state_e state_q;
  logic      tgt_misaligned;
  logic      advance;

  pc_adder #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_adder (
    .base (pc_out),
    .sum  (pc_next_seq_out)
  );

  assign tgt_misaligned = |redirect_target_in[1:0];
  assign advance        = fetch_ready_in && !stall_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= RUN;
      pc_out          <= RESET_VECTOR;
      epc_out         <= '0;
      fetch_valid_out <= 1'b1;
      misalign_out    <= 1'b0;
    end else begin
      misalign_out <= 1'b0;
      unique case (state_q)
        RUN: begin
          if (trap_in) begin
            epc_out <= pc_out;
            pc_out  <= TRAP_VECTOR;
          end else if (redirect_in && tgt_misaligned) begin
            epc_out      <= pc_out;
            pc_out       <= TRAP_VECTOR;
            misalign_out <= 1'b1;
          end else if (redirect_in) begin
            pc_out <= redirect_target_in;
          end else if (mret_in) begin
            pc_out <= epc_out;
          end else if (advance) begin
            pc_out <= pc_next_seq_out;
          end
          // Halt lands after this cycle's PC update.
          if (halt_in) begin
            state_q         <= HALTED;
            fetch_valid_out <= 1'b0;
          end
        end
        HALTED: begin
          if (trap_in) begin
            epc_out         <= pc_out;
            pc_out          <= TRAP_VECTOR;
            state_q         <= RUN;
            fetch_valid_out <= 1'b1;
          end else if (resume_in) begin
            state_q         <= RUN;
            fetch_valid_out <= 1'b1;
          end
        end
        default: begin
          state_q         <= RUN;
          fetch_valid_out <= 1'b1;
        end
      endcase
    end
  end

endmodule
